// File: rtl/demux1to4_pkg.sv
// Shared definitions for the 1:4 result router.
//   DATA_W_DEF : default data word width
//   NUM_CH     : number of output channels
//   STAT_W     : width of the optional per-channel delivery counters
//   ch_sel_t   : channel select type (0..3)
package demux1to4_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NUM_CH     = 4;
    localparam int STAT_W     = 16;

    typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : load wr_data this cycle (only raised when can_accept=1)
//   wr_data     : word to store
//   rd_ready    : consumer takes the held word this cycle
//   valid       : slot holds an undelivered word
//   data        : held word (retained after delivery, not cleared)
//   can_accept  : slot is empty or is being drained this cycle
module demux_slot
    import demux1to4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              can_accept
);

    logic full;

    // A full slot can still take a new word when its current word leaves in
    // the same cycle, giving one word per cycle when streaming.
    assign can_accept = ~full | rd_ready;
    assign valid      = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (wr_en) begin
                data <= wr_data;
                full <= 1'b1;
            end else if (full && rd_ready) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux1to4_router.sv
// 1:4 router: steers one valid/ready input stream to one of four buffered
// output channels selected by in_sel. Each channel stalls independently.
// Optional feature macro: DEMUX1TO4_STATS_EN adds per-channel 16-bit
// delivered-word counters stat0..stat3 and a synchronous clear stat_clr.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stat_clr            : (stats build) clear all counters, wins over delivery
//   stat0..stat3        : (stats build) delivered-word counters
//   in_data/in_sel      : word and destination channel
//   in_valid/in_ready   : input handshake (in_ready combinational)
//   outN_data/valid     : channel N slot contents and occupancy
//   outN_ready          : consumer N takes the word
module demux1to4_router
    import demux1to4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DEMUX1TO4_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat0,
    output logic [STAT_W-1:0] stat1,
    output logic [STAT_W-1:0] stat2,
    output logic [STAT_W-1:0] stat3,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  ch_sel_t           in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [DATA_W-1:0] out1_data,
    output logic [DATA_W-1:0] out2_data,
    output logic [DATA_W-1:0] out3_data,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic              out2_valid,
    output logic              out3_valid,
    input  logic              out0_ready,
    input  logic              out1_ready,
    input  logic              out2_ready,
    input  logic              out3_ready
);

    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] can_accept;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_ready;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic              accept;

    assign slot_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

    // Only the selected channel gates the input, so a stalled channel never
    // blocks traffic headed elsewhere.
    assign in_ready = can_accept[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_en[n] = accept && (in_sel == ch_sel_t'(n));
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en[n]),
            .wr_data   (in_data),
            .rd_ready  (slot_ready[n]),
            .valid     (slot_valid[n]),
            .data      (slot_data[n]),
            .can_accept(can_accept[n])
        );
    end

    assign out0_data  = slot_data[0];
    assign out1_data  = slot_data[1];
    assign out2_data  = slot_data[2];
    assign out3_data  = slot_data[3];
    assign out0_valid = slot_valid[0];
    assign out1_valid = slot_valid[1];
    assign out2_valid = slot_valid[2];
    assign out3_valid = slot_valid[3];

`ifdef DEMUX1TO4_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = 1;

    logic [STAT_W-1:0] stat_q [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) stat_q[n] <= '0;
        end else if (stat_clr) begin
            for (int n = 0; n < NUM_CH; n++) stat_q[n] <= '0;
        end else begin
            // Natural wrap at 0xFFFF -> 0x0000.
            for (int n = 0; n < NUM_CH; n++) begin
                if (slot_valid[n] && slot_ready[n]) stat_q[n] <= stat_q[n] + STAT_ONE;
            end
        end
    end

    assign stat0 = stat_q[0];
    assign stat1 = stat_q[1];
    assign stat2 = stat_q[2];
    assign stat3 = stat_q[3];
`endif

endmodule

// File: tb/tb_demux1to4_router.sv
// Self-checking bench for demux1to4_router: directed vector table, hand-written
// reset/streaming sequences, a randomized soak against a queue-based model,
// and (stats build only) counter checks.
module tb_demux1to4_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data, out1_data, out2_data, out3_data;
    logic        out0_valid, out1_valid, out2_valid, out3_valid;
    logic [3:0]  rdy;
`ifdef DEMUX1TO4_STATS_EN
    logic        stat_clr;
    logic [15:0] stat0, stat1, stat2, stat3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux1to4_router dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DEMUX1TO4_STATS_EN
        .stat_clr  (stat_clr),
        .stat0     (stat0),
        .stat1     (stat1),
        .stat2     (stat2),
        .stat3     (stat3),
`endif
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out0_valid(out0_valid),
        .out1_valid(out1_valid),
        .out2_valid(out2_valid),
        .out3_valid(out3_valid),
        .out0_ready(rdy[0]),
        .out1_ready(rdy[1]),
        .out2_ready(rdy[2]),
        .out3_ready(rdy[3])
    );

    logic [31:0] od [4];
    logic [3:0]  ov;
    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;
    assign ov    = {out3_valid, out2_valid, out1_valid, out0_valid};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        vld;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_v;
        int          ch;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [9];

    // Reference model: one FIFO per channel with capacity one word.
    logic [31:0] mq [4][$];
    int          n_acc;
    int          n_del;

    initial begin
        logic        m_rdy;
        logic [31:0] w;

        // Sequence from a fresh reset; expected values worked out by hand.
        tbl[0] = '{2'd2, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 32'hDEADBEEF};
        tbl[1] = '{2'd1, 32'h11111111, 1'b1, 4'b0000, 1'b1, 4'b0110, 1, 32'h11111111};
        tbl[2] = '{2'd1, 32'h12345678, 1'b1, 4'b0000, 1'b0, 4'b0110, 1, 32'h11111111};
        tbl[3] = '{2'd3, 32'h12345678, 1'b1, 4'b0000, 1'b1, 4'b1110, 3, 32'h12345678};
        tbl[4] = '{2'd0, 32'h00000001, 1'b1, 4'b0000, 1'b1, 4'b1111, 0, 32'h00000001};
        tbl[5] = '{2'd0, 32'h00000002, 1'b1, 4'b0001, 1'b1, 4'b1111, 0, 32'h00000002};
        tbl[6] = '{2'd2, 32'h0000AAAA, 1'b0, 4'b0100, 1'b1, 4'b1011, 2, 32'hDEADBEEF};
        tbl[7] = '{2'd1, 32'h00000055, 1'b1, 4'b0010, 1'b1, 4'b1011, 1, 32'h00000055};
        tbl[8] = '{2'd3, 32'h00000066, 1'b0, 4'b1111, 1'b1, 4'b0000, 3, 32'h12345678};

        rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; rdy = '0;
`ifdef DEMUX1TO4_STATS_EN
        stat_clr = 1'b0;
`endif
        #3;
        check("reset_valid", 64'(ov), 64'h0);
        for (int n = 0; n < 4; n++) check($sformatf("reset_data%0d", n), 64'(od[n]), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1 check($sformatf("reset_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_sel = tbl[i].sel; in_data = tbl[i].data; in_valid = tbl[i].vld; rdy = tbl[i].rdy;
            #1 check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 64'(ov), 64'(tbl[i].exp_v));
            check($sformatf("vec%0d_data", i), 64'(od[tbl[i].ch]), 64'(tbl[i].exp_d));
        end

        // Asynchronous reset with slot 2 full: clears without a clock edge.
        @(negedge clk);
        in_sel = 2'd2; in_data = 32'hCAFEF00D; in_valid = 1'b1; rdy = '0;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_slot2", 64'(out2_valid), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 64'(ov), 64'h0);
        check("async_reset_data2", 64'(out2_data), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        in_sel = 2'd2;
        #1 check("post_reset_in_ready", 64'(in_ready), 64'h1);

        // Stream 8 words to channel 0 with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_sel = 2'd0; in_data = 32'(100 + i); in_valid = 1'b1; rdy = 4'b0001;
            #1 check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'h1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_valid", i), 64'(out0_valid), 64'h1);
            check($sformatf("stream%0d_data", i), 64'(out0_data), 64'(100 + i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("stream_drained", 64'(out0_valid), 64'h0);

`ifdef DEMUX1TO4_STATS_EN
        // Counters: clear, deliver three words on channel 2.
        @(negedge clk);
        stat_clr = 1'b1; rdy = '0;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat2_cleared", 64'(stat2), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_sel = 2'd2; in_data = 32'(i); in_valid = 1'b1; rdy = 4'b0100;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("stat2_three", 64'(stat2), 64'h3);
        check("stat0_untouched", 64'(stat0), 64'h0);
        // Clear coinciding with a delivery: clear wins.
        rdy = 4'b0000; in_sel = 2'd2; in_data = 32'h77; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rdy = 4'b0100; stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0; rdy = '0;
        check("stat2_clr_wins", 64'(stat2), 64'h0);
        check("stat2_clr_delivered", 64'(out2_valid), 64'h0);
`endif

        // Randomized soak against the queue model, from a clean reset.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; rdy = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) mq[n].delete();
        n_acc = 0; n_del = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = $urandom;
            in_valid = 1'($urandom_range(0, 1));
            rdy      = 4'($urandom);
            #1;
            m_rdy = (mq[in_sel].size() == 0) || rdy[in_sel];
            check("soak_in_ready", 64'(in_ready), 64'(m_rdy));
            for (int n = 0; n < 4; n++) begin
                check("soak_valid", 64'(ov[n]), 64'(mq[n].size() != 0));
                if (mq[n].size() != 0) check("soak_data", 64'(od[n]), 64'(mq[n][0]));
            end
            for (int n = 0; n < 4; n++) begin
                if (mq[n].size() != 0 && rdy[n]) begin
                    w = mq[n].pop_front();
                    n_del++;
                end
            end
            if (in_valid && m_rdy) begin
                mq[in_sel].push_back(in_data);
                n_acc++;
            end
        end
        // Drain everything and confirm nothing is left or lost.
        @(negedge clk);
        in_valid = 1'b0; rdy = 4'b1111;
        for (int n = 0; n < 4; n++) n_del += mq[n].size();
        @(negedge clk);
        check("soak_drained", 64'(ov), 64'h0);
        check("soak_acc_eq_del", 64'(n_acc), 64'(n_del));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
